// File: rtl/vdispatch_ring_param_if.sv
// Bundles the issue-side and lane-side signals of the vector dispatch ring.
// The issue stage drives through master and the ring sits behind slave.
interface vdispatch_ring_param_if #(
    parameter int NUMSLOTS = 2,
    parameter int INSTRW   = 157,
    parameter int ELMW     = 7,
    parameter int CNTW     = 3
);
    logic                       in_valid;
    logic                       in_ready;
    logic [INSTRW-1:0]          in_instr;
    logic [ELMW-1:0]            in_rdelm;
    logic [ELMW-1:0]            in_wrelm;
    logic [CNTW-1:0]            in_count;
    logic                       rotate;
    logic [NUMSLOTS-1:0]        increment;
    logic [NUMSLOTS-1:0]        squash;
    logic                       rd_sub;
    logic                       wr_sub;
    logic [ELMW-1:0]            rd_step;
    logic [ELMW-1:0]            wr_step;
    logic [CNTW-1:0]            cnt_step;
    logic [NUMSLOTS*INSTRW-1:0] instr;
    logic [NUMSLOTS-1:0]        valid;
    logic [NUMSLOTS-1:0]        first;
    logic [NUMSLOTS*ELMW-1:0]   rdelm;
    logic [NUMSLOTS*ELMW-1:0]   wrelm;
    logic [NUMSLOTS*CNTW-1:0]   count;
    logic [NUMSLOTS-1:0]        done;

    modport master (
        output in_valid, in_instr, in_rdelm, in_wrelm, in_count, rotate,
               increment, squash, rd_sub, wr_sub, rd_step, wr_step, cnt_step,
        input  in_ready, instr, valid, first, rdelm, wrelm, count, done
    );

    modport slave (
        input  in_valid, in_instr, in_rdelm, in_wrelm, in_count, rotate,
               increment, squash, rd_sub, wr_sub, rd_step, wr_step, cnt_step,
        output in_ready, instr, valid, first, rdelm, wrelm, count, done
    );
endinterface

// File: rtl/vdispatch_ring_param.sv
// Vector-lane dispatch ring: NUMSLOTS in-flight instructions that shift on accept,
// recirculate on rotate, advance their element pointers and retire themselves.
module vdispatch_ring_param #(
    parameter int NUMSLOTS = 2,
    parameter int INSTRW   = 157,
    parameter int ELMW     = 7,
    parameter int CNTW     = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    vdispatch_ring_param_if.slave  bus
);
    localparam int LASTS = NUMSLOTS - 1;

    logic [INSTRW-1:0]   instr_r [NUMSLOTS];
    logic [ELMW-1:0]     rdelm_r [NUMSLOTS];
    logic [ELMW-1:0]     wrelm_r [NUMSLOTS];
    logic [CNTW-1:0]     count_r [NUMSLOTS];
    logic [NUMSLOTS-1:0] valid_r;
    logic [NUMSLOTS-1:0] first_r;
    logic [NUMSLOTS-1:0] done_r;

    logic [INSTRW-1:0]   upd_instr_s [NUMSLOTS];
    logic [ELMW-1:0]     upd_rdelm_s [NUMSLOTS];
    logic [ELMW-1:0]     upd_wrelm_s [NUMSLOTS];
    logic [CNTW-1:0]     upd_count_s [NUMSLOTS];
    logic [NUMSLOTS-1:0] upd_valid_s;
    logic [NUMSLOTS-1:0] upd_first_s;
    logic [NUMSLOTS-1:0] retire_s;

    logic [INSTRW-1:0]   nxt_instr_s [NUMSLOTS];
    logic [ELMW-1:0]     nxt_rdelm_s [NUMSLOTS];
    logic [ELMW-1:0]     nxt_wrelm_s [NUMSLOTS];
    logic [CNTW-1:0]     nxt_count_s [NUMSLOTS];
    logic [NUMSLOTS-1:0] nxt_valid_s;
    logic [NUMSLOTS-1:0] nxt_first_s;

    logic accept_s;
    logic move_s;

    // Element pointers wrap modulo 2^ELMW in either direction.
    function automatic logic [ELMW-1:0] step_ptr(
        input logic [ELMW-1:0] ptr,
        input logic [ELMW-1:0] step,
        input logic            sub
    );
        logic [ELMW-1:0] res;
        if (sub) begin
            res = ptr - step;
        end else begin
            res = ptr + step;
        end
        return res;
    endfunction

    // A full last slot blocks entry because an accept would push it off the end.
    assign bus.in_ready = ~bus.rotate & ~valid_r[LASTS];
    assign accept_s     = bus.in_valid & bus.in_ready;
    assign move_s       = accept_s | bus.rotate;

    // Per-source-slot update: squash wins over increment, increment may retire.
    always_comb begin
        for (int s = 0; s < NUMSLOTS; s++) begin
            upd_instr_s[s] = instr_r[s];
            upd_valid_s[s] = valid_r[s];
            upd_first_s[s] = first_r[s];
            upd_rdelm_s[s] = rdelm_r[s];
            upd_wrelm_s[s] = wrelm_r[s];
            upd_count_s[s] = count_r[s];
            retire_s[s]    = 1'b0;
            if (bus.squash[s]) begin
                upd_valid_s[s] = 1'b0;
            end else if (bus.increment[s] & valid_r[s]) begin
                upd_rdelm_s[s] = step_ptr(rdelm_r[s], bus.rd_step, bus.rd_sub);
                upd_wrelm_s[s] = step_ptr(wrelm_r[s], bus.wr_step, bus.wr_sub);
                upd_first_s[s] = 1'b0;
                if (count_r[s] <= bus.cnt_step) begin
                    upd_count_s[s] = {CNTW{1'b0}};
                    upd_valid_s[s] = 1'b0;
                    retire_s[s]    = 1'b1;
                end else begin
                    upd_count_s[s] = count_r[s] - bus.cnt_step;
                end
            end else begin
                upd_valid_s[s] = valid_r[s];
            end
        end
    end

    // Route updated slots to their destinations; slot 0 is fed by the input or the ring tail.
    always_comb begin
        for (int i = 0; i < NUMSLOTS; i++) begin
            nxt_instr_s[i] = upd_instr_s[i];
            nxt_valid_s[i] = upd_valid_s[i];
            nxt_first_s[i] = upd_first_s[i];
            nxt_rdelm_s[i] = upd_rdelm_s[i];
            nxt_wrelm_s[i] = upd_wrelm_s[i];
            nxt_count_s[i] = upd_count_s[i];
        end
        if (move_s) begin
            for (int i = 1; i < NUMSLOTS; i++) begin
                nxt_instr_s[i] = upd_instr_s[i-1];
                nxt_valid_s[i] = upd_valid_s[i-1];
                nxt_first_s[i] = upd_first_s[i-1];
                nxt_rdelm_s[i] = upd_rdelm_s[i-1];
                nxt_wrelm_s[i] = upd_wrelm_s[i-1];
                nxt_count_s[i] = upd_count_s[i-1];
            end
            if (accept_s) begin
                nxt_instr_s[0] = bus.in_instr;
                nxt_valid_s[0] = (bus.in_count != {CNTW{1'b0}});
                nxt_first_s[0] = 1'b1;
                nxt_rdelm_s[0] = bus.in_rdelm;
                nxt_wrelm_s[0] = bus.in_wrelm;
                nxt_count_s[0] = bus.in_count;
            end else begin
                nxt_instr_s[0] = upd_instr_s[LASTS];
                nxt_valid_s[0] = upd_valid_s[LASTS];
                nxt_first_s[0] = upd_first_s[LASTS];
                nxt_rdelm_s[0] = upd_rdelm_s[LASTS];
                nxt_wrelm_s[0] = upd_wrelm_s[LASTS];
                nxt_count_s[0] = upd_count_s[LASTS];
            end
        end else begin
            nxt_valid_s[0] = upd_valid_s[0];
        end
    end

    // Slot state and retire pulses; reset drops everything without a done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUMSLOTS; i++) begin
                instr_r[i] <= {INSTRW{1'b0}};
                rdelm_r[i] <= {ELMW{1'b0}};
                wrelm_r[i] <= {ELMW{1'b0}};
                count_r[i] <= {CNTW{1'b0}};
            end
            valid_r <= {NUMSLOTS{1'b0}};
            first_r <= {NUMSLOTS{1'b0}};
            done_r  <= {NUMSLOTS{1'b0}};
        end else begin
            for (int i = 0; i < NUMSLOTS; i++) begin
                instr_r[i] <= nxt_instr_s[i];
                rdelm_r[i] <= nxt_rdelm_s[i];
                wrelm_r[i] <= nxt_wrelm_s[i];
                count_r[i] <= nxt_count_s[i];
            end
            valid_r <= nxt_valid_s;
            first_r <= nxt_first_s;
            done_r  <= retire_s;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUMSLOTS; g++) begin : g_pack
            assign bus.instr[g*INSTRW +: INSTRW] = instr_r[g];
            assign bus.rdelm[g*ELMW +: ELMW]     = rdelm_r[g];
            assign bus.wrelm[g*ELMW +: ELMW]     = wrelm_r[g];
            assign bus.count[g*CNTW +: CNTW]     = count_r[g];
        end
    endgenerate

    assign bus.valid = valid_r;
    assign bus.first = first_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_vdispatch_ring_param.sv
// Self-checking bench for vdispatch_ring_param: directed scenarios followed by
// random traffic, all compared against a slot-list reference model.
module tb_vdispatch_ring_param;
    localparam int N  = 2;
    localparam int IW = 157;
    localparam int EW = 7;
    localparam int CW = 3;
    localparam int PM = 1 << EW;

    typedef struct {
        logic [IW-1:0] instr;
        bit            v;
        bit            f;
        int            rd;
        int            wr;
        int            cnt;
    } slot_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_vec = 0;
    int   n_err = 0;
    slot_t m [N];
    bit    m_done [N];
    logic [IW-1:0] instr_b;
    logic [IW-1:0] instr_c;

    always #5 clk = ~clk;

    vdispatch_ring_param_if #(.NUMSLOTS(N), .INSTRW(IW), .ELMW(EW), .CNTW(CW)) bus ();

    vdispatch_ring_param #(.NUMSLOTS(N), .INSTRW(IW), .ELMW(EW), .CNTW(CW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] rand_instr();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[IW-1:0];
    endfunction

    function automatic int wrap_ptr(input int p);
        return ((p % PM) + PM) % PM;
    endfunction

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_rdelm  = '0;
        bus.in_wrelm  = '0;
        bus.in_count  = '0;
        bus.rotate    = 1'b0;
        bus.increment = '0;
        bus.squash    = '0;
        bus.rd_sub    = 1'b0;
        bus.wr_sub    = 1'b0;
        bus.rd_step   = '0;
        bus.wr_step   = '0;
        bus.cnt_step  = '0;
    endtask

    task automatic model_clear();
        for (int s = 0; s < N; s++) begin
            m[s] = '{instr: '0, v: 1'b0, f: 1'b0, rd: 0, wr: 0, cnt: 0};
            m_done[s] = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [EW-1:0] rd_e;
        logic [EW-1:0] wr_e;
        logic [CW-1:0] cnt_e;
        for (int s = 0; s < N; s++) begin
            rd_e  = m[s].rd[EW-1:0];
            wr_e  = m[s].wr[EW-1:0];
            cnt_e = m[s].cnt[CW-1:0];
            chk($sformatf("instr%0d", s), bus.instr[s*IW +: IW], m[s].instr);
            chk($sformatf("valid%0d", s), bus.valid[s], m[s].v);
            chk($sformatf("first%0d", s), bus.first[s], m[s].f);
            chk($sformatf("rdelm%0d", s), bus.rdelm[s*EW +: EW], rd_e);
            chk($sformatf("wrelm%0d", s), bus.wrelm[s*EW +: EW], wr_e);
            chk($sformatf("count%0d", s), bus.count[s*CW +: CW], cnt_e);
            chk($sformatf("done%0d", s), bus.done[s], m_done[s]);
        end
    endtask

    // Apply the inputs currently driven for one clock, advancing the model alongside.
    task automatic step();
        slot_t p [N];
        slot_t nx [N];
        bit    dn [N];
        bit    rdy;
        bit    acc;
        #1;
        rdy = !bus.rotate && !m[N-1].v;
        chk("in_ready", bus.in_ready, rdy);
        acc = bus.in_valid && rdy;
        for (int s = 0; s < N; s++) begin
            p[s]  = m[s];
            dn[s] = 1'b0;
            if (bus.squash[s]) begin
                p[s].v = 1'b0;
            end else if (bus.increment[s] && m[s].v) begin
                p[s].rd = wrap_ptr(bus.rd_sub ? m[s].rd - int'(bus.rd_step) : m[s].rd + int'(bus.rd_step));
                p[s].wr = wrap_ptr(bus.wr_sub ? m[s].wr - int'(bus.wr_step) : m[s].wr + int'(bus.wr_step));
                p[s].f  = 1'b0;
                if (m[s].cnt <= int'(bus.cnt_step)) begin
                    p[s].cnt = 0;
                    p[s].v   = 1'b0;
                    dn[s]    = 1'b1;
                end else begin
                    p[s].cnt = m[s].cnt - int'(bus.cnt_step);
                end
            end
        end
        if (acc) begin
            nx[0] = '{instr: bus.in_instr, v: (bus.in_count != 0), f: 1'b1,
                      rd: int'(bus.in_rdelm), wr: int'(bus.in_wrelm), cnt: int'(bus.in_count)};
            for (int i = 1; i < N; i++) nx[i] = p[i-1];
        end else if (bus.rotate) begin
            for (int s = 0; s < N; s++) nx[(s + 1) % N] = p[s];
        end else begin
            for (int s = 0; s < N; s++) nx[s] = p[s];
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < N; s++) begin
            m[s]      = nx[s];
            m_done[s] = dn[s];
        end
        check_all();
    endtask

    task automatic enqueue(input logic [IW-1:0] ins, input int rd, input int wr, input int cnt);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_rdelm = EW'(rd);
        bus.in_wrelm = EW'(wr);
        bus.in_count = CW'(cnt);
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        model_clear();
        resetn = 1'b0;
        #1;
        check_all();
        #12;
        resetn = 1'b1;

        // Accept one instruction and walk it to retirement.
        enqueue(rand_instr(), 0, 4, 5);
        chk("t1_valid", bus.valid, 2'b01);
        chk("t1_first", bus.first, 2'b01);
        chk("t1_rdelm0", bus.rdelm[EW-1:0], 7'd0);
        chk("t1_count0", bus.count[CW-1:0], 3'd5);
        bus.increment = 2'b01;
        bus.rd_step   = 7'd2;
        bus.wr_step   = 7'd2;
        bus.cnt_step  = 3'd2;
        step();
        chk("t2_count_a", bus.count[CW-1:0], 3'd3);
        chk("t2_first", bus.first, 2'b00);
        step();
        chk("t2_count_b", bus.count[CW-1:0], 3'd1);
        step();
        chk("t2_valid", bus.valid, 2'b00);
        chk("t2_done", bus.done, 2'b01);
        bus.increment = 2'b00;
        step();
        chk("t2_done_clr", bus.done, 2'b00);

        // Fill both slots and rotate a full turn while incrementing.
        instr_b = rand_instr();
        instr_c = rand_instr();
        enqueue(instr_b, 10, 20, 7);
        enqueue(instr_c, 30, 40, 6);
        bus.rotate    = 1'b1;
        bus.increment = 2'b11;
        bus.cnt_step  = 3'd1;
        bus.rd_step   = 7'd1;
        bus.wr_step   = 7'd1;
        step();
        chk("t3_ready", bus.in_ready, 1'b0);
        step();
        bus.rotate    = 1'b0;
        bus.increment = 2'b00;
        chk("t3_instr1", bus.instr[IW +: IW], instr_b);
        chk("t3_instr0", bus.instr[IW-1:0], instr_c);
        chk("t3_count1", bus.count[CW +: CW], 3'd5);
        chk("t3_count0", bus.count[CW-1:0], 3'd4);

        // Pointer wrap in both directions.
        bus.squash = 2'b11;
        step();
        bus.squash = 2'b00;
        enqueue(rand_instr(), 'h7E, 0, 7);
        bus.increment = 2'b01;
        bus.rd_step   = 7'd4;
        bus.rd_sub    = 1'b0;
        step();
        chk("t4_wrap_up", bus.rdelm[EW-1:0], 7'h02);
        bus.increment = 2'b00;
        enqueue(rand_instr(), 1, 0, 7);
        bus.increment = 2'b01;
        bus.rd_step   = 7'd3;
        bus.rd_sub    = 1'b1;
        step();
        chk("t4_wrap_dn", bus.rdelm[EW-1:0], 7'h7E);

        // Squash beats increment; zero-count accept is dropped.
        bus.squash    = 2'b10;
        bus.increment = 2'b10;
        bus.cnt_step  = 3'd7;
        step();
        chk("t5_valid1", bus.valid[1], 1'b0);
        chk("t5_done", bus.done, 2'b00);
        bus.squash    = 2'b00;
        bus.increment = 2'b00;
        enqueue(rand_instr(), 3, 3, 0);
        chk("t5_zero_cnt", bus.valid[0], 1'b0);

        // Asynchronous reset in the middle of a rotate.
        bus.squash = 2'b11;
        step();
        bus.squash = 2'b00;
        enqueue(rand_instr(), 5, 6, 7);
        enqueue(rand_instr(), 7, 8, 7);
        bus.rotate    = 1'b1;
        bus.increment = 2'b11;
        bus.cnt_step  = 3'd1;
        step();
        #2;
        resetn = 1'b0;
        #1;
        model_clear();
        check_all();
        chk("t6_valid", bus.valid, 2'b00);
        chk("t6_done", bus.done, 2'b00);
        drive_idle();
        #3;
        resetn = 1'b1;
        #1;
        chk("t6_ready", bus.in_ready, 1'b1);
        step();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            bus.rotate    = ($urandom_range(0, 3) == 0);
            bus.in_valid  = $urandom_range(0, 1) == 1;
            bus.in_instr  = rand_instr();
            bus.in_rdelm  = EW'($urandom);
            bus.in_wrelm  = EW'($urandom);
            bus.in_count  = CW'($urandom);
            bus.increment = N'($urandom);
            for (int i = 0; i < N; i++) bus.squash[i] = ($urandom_range(0, 7) == 0);
            bus.rd_sub    = $urandom_range(0, 1) == 1;
            bus.wr_sub    = $urandom_range(0, 1) == 1;
            bus.rd_step   = EW'($urandom);
            bus.wr_step   = EW'($urandom);
            bus.cnt_step  = CW'($urandom_range(0, 3));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
